// File: rtl/video_pixel_feeder_pkg.sv
// video_pkg: display timing constants and feeder FSM encoding
package video_pkg;
  localparam int H_DISP = 1936;
  localparam int V_DISP = 1088;
  localparam int FRAME_PIX = H_DISP * V_DISP;
  typedef logic [1:0] state_t;
  localparam state_t S_SYNC  = 2'd0;
  localparam state_t S_ARM   = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_FLUSH = 2'd3;
endpackage

// File: rtl/video_pixel_feeder_if.sv
// video_pixel_feeder_if: valid/ready pixel stream from the frame source
interface video_pixel_feeder_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_valid;
  logic              s_ready;
  modport master (output s_data, s_sof, s_valid, input s_ready);
  modport slave  (input s_data, s_sof, s_valid, output s_ready);
endinterface

// File: rtl/video_pixel_feeder_sync_fifo.sv
// video_sync_fifo: single-clock FIFO with registered read port and show-ahead head
module video_sync_fifo #(
  parameter int W  = 9,
  parameter int AW = 12
) (
  input  logic          pixel_clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic [W-1:0]  dout,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_wr, do_rd;
  assign level = wr_ptr - rd_ptr;
  assign full  = level == (AW+1)'(2**AW);
  assign empty = level == '0;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty && !flush;
  // storage array, written on accepted beats only
  always_ff @(posedge pixel_clk)
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  // pointers and registered read data; dout returns to zero when not popping
  always_ff @(posedge pixel_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_wr);
      rd_ptr <= flush ? wr_ptr : rd_ptr + (AW+1)'(do_rd);
      dout   <= do_rd ? mem[rd_ptr[AW-1:0]] : '0;
    end
endmodule

// File: rtl/video_pixel_feeder.sv
// video_pixel_feeder: frame-aligned pixel buffer feeding the HDMI timing generator
module video_pixel_feeder import video_pkg::*; #(
  parameter int              DATA_W    = 8,
  parameter int              AW        = 12,
  parameter int              FRAME_PIX = video_pkg::FRAME_PIX,
  parameter int              CNT_W     = 22,
  parameter logic [DATA_W-1:0] UFLOW_VAL = '0
) (
  input  logic                pixel_clk,
  input  logic                sys_rst_n,
  video_pixel_feeder_if.slave s_if,
  input  logic                data_req,
  input  logic                TFT_begin,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   pixel_data,
  output logic [AW:0]         fifo_level,
  output logic                frame_err,
  output logic                underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_PIX);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              full, empty, wr_en, req, tft_run, frame_ok, uf_px, unused_bits;
  logic [DATA_W:0]   dout, head;
  assign s_if.s_ready = sys_rst_n && (state == S_SYNC || (state != S_FLUSH && !full));
  assign wr_en    = s_if.s_valid && s_if.s_ready && (state != S_SYNC || s_if.s_sof);
  assign req      = state == S_RUN && data_req && !TFT_begin;
  assign tft_run  = state == S_RUN && TFT_begin;
  assign frame_ok = cnt == CNT_MAX && !empty && head[DATA_W];
  assign pixel_data  = uf_px ? UFLOW_VAL : dout[DATA_W-1:0];
  assign unused_bits = ^{dout[DATA_W], head[DATA_W-1:0]};
  video_sync_fifo #(.W(DATA_W + 1), .AW(AW)) u_fifo (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .rd_en     (req),
    .flush     (state == S_FLUSH),
    .din       ({s_if.s_sof, s_if.s_data}),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level),
    .dout      (dout),
    .head      (head)
  );
  // frame alignment: wait for sof, arm on display start, run, flush on mismatch
  always_ff @(posedge pixel_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= S_SYNC;
    else
      state <= state == S_SYNC ? (wr_en ? S_ARM : S_SYNC) :
               state == S_ARM  ? (TFT_begin ? S_RUN : S_ARM) :
               state == S_RUN  ? (TFT_begin && !frame_ok ? S_FLUSH : S_RUN) : S_SYNC;
  // pixels requested since display frame start, saturating at one frame
  always_ff @(posedge pixel_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else if ((state == S_ARM && TFT_begin) || tft_run || state == S_FLUSH) cnt <= '0;
    else if (req && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  // resync pulse, underflow pixel select and sticky underflow (set beats clear)
  always_ff @(posedge pixel_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      frame_err <= 1'b0;
      uf_px     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      frame_err <= tft_run && !frame_ok;
      uf_px     <= req && empty;
      underflow <= (req && empty) || (underflow && !err_clr);
    end
endmodule

// File: doc/video_pixel_feeder.md
Name: video_pixel_feeder

Overview:
- Upstream stage of the HDMI timing generator.
- Buffers a valid/ready pixel stream from the frame source (DDR reader / ISP) in an internal FIFO.
- Pops one pixel per `data_req` cycle, so `pixel_data` is valid in the cycle the timing generator raises `video_de`.
- Keeps the source stream frame-aligned to the display using `TFT_begin` and a start-of-frame tag, resyncing after any mismatch.

Parameters:
- DATA_W, 8, pixel width.
- AW, 12, FIFO address width (depth 2^AW = 4096 entries, ~2 lines).
- FRAME_PIX, 2106368, active pixels per frame (1936*1088).
- CNT_W, 22, pop counter width (must hold FRAME_PIX).
- UFLOW_VAL, 8'd0, pixel driven on underflow.

Ports:
- pixel_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_W  source pixel.
- s_sof  in  1  marks the first pixel of a source frame.
- s_valid  in  1  source beat valid.
- s_ready  out  1  block accepts beat this cycle.
- data_req  in  1  pixel request from the timing generator (one cycle ahead of de).
- TFT_begin  in  1  one-cycle pulse at display frame start (h=0, v=0).
- pixel_data  out  DATA_W  registered pixel to the timing generator.
- fifo_level  out  AW+1  entries currently stored.
- frame_err  out  1  one-cycle pulse when a resync is triggered.
- underflow  out  1  sticky; set on a request against an empty FIFO.
- err_clr  in  1  synchronous clear of `underflow`.

Behaviour:
- Async reset sets: state S_SYNC, FIFO empty, `pixel_data`=0, `fifo_level`=0, `underflow`=0, `frame_err`=0, pop counter=0. `s_ready` is 0 while reset is asserted.
- FIFO entries are DATA_W+1 bits wide: {sof, data}.
- A write occurs on s_valid && s_ready.
- Read latency is 1: a pop in cycle t (data_req=1, FIFO not empty) gives pixel_data=mem[rd] at t+1.
- pixel_data holds 0 in any cycle after data_req=0.
- Same-cycle write and pop: level unchanged. Write to a full FIFO is impossible: s_ready=0 when level == 2^AW.
- States:
  - S_SYNC:
    - s_ready=1 regardless of level (FIFO is empty here).
    - Beats with s_sof=0 are discarded.
    - The first beat with s_sof=1 is written, then go to S_ARM.
    - data_req is ignored; pixel_data=0.
  - S_ARM:
    - Normal writes (s_ready = !full).
    - On TFT_begin: pop counter:=0, go to S_RUN.
    - data_req is ignored, including in the same cycle as TFT_begin.
  - S_RUN:
    - Normal writes. A second s_sof beat is written normally (it belongs to the next frame).
    - data_req pops and increments the pop counter. The counter saturates at FRAME_PIX.
    - data_req with an empty FIFO: pixel_data=UFLOW_VAL at t+1, underflow:=1, counter still increments, no pointer move.
    - On TFT_begin, stay in S_RUN and clear the counter if counter == FRAME_PIX AND the FIFO is non-empty AND the head entry has sof=1.
    - Otherwise go to S_FLUSH and pulse frame_err for one cycle.
    - TFT_begin takes priority over a same-cycle data_req.
  - S_FLUSH (one cycle): s_ready=0; read pointer := write pointer (FIFO emptied); counter:=0; go to S_SYNC.
- `underflow`:
  - Cleared by err_clr.
  - err_clr and a new underflow in the same cycle: set wins.
- Reset mid-frame: everything returns to reset values immediately. The first pixel accepted afterwards must carry s_sof.

Decomposition:
- Package video_pkg holds:
  - Timing constants H_DISP=1936, V_DISP=1088, FRAME_PIX.
  - State enum {S_SYNC, S_ARM, S_RUN, S_FLUSH}.
- Sub-module video_sync_fifo:
  - Parameterised width/AW.
  - Ports: wr_en, rd_en, flush, full, empty, level, registered dout, head output (show-ahead of mem[rd] for the sof check).
- The FSM, counter and error flags live in video_pixel_feeder.

Test Plan:
- Bench parameters: FRAME_PIX=16, AW=3.
- Reset, then beats 0x05,0x06 (sof=0) followed by 0x10 (sof=1) -> first two discarded, level=1, state S_ARM.
- Preload 8 pixels 0x10..0x17 (first with sof), TFT_begin, then 8 consecutive data_req -> pixel_data = 0x10..0x17 one cycle after each req; 0 after; level 0 at end.
- FIFO full (8 entries) with s_valid held -> s_ready=0; one data_req -> s_ready=1 next cycle, write and pop together keep level at 8.
- In S_RUN with empty FIFO, data_req for 1 cycle -> pixel_data=0x00 next cycle, underflow=1 and held; err_clr -> underflow=0.
- Full frame of 16 pops, next frame's sof at head, TFT_begin -> stays S_RUN, frame_err=0. Repeat with only 15 pops -> frame_err pulse, level=0, state S_SYNC, non-sof beats discarded.
- Async reset asserted mid-S_RUN with level=5 -> level=0, pixel_data=0, s_ready=0 immediately.
